// File: rtl/mod_counter.sv
// mod_counter: up/down modulo counter over 0..limit with wrap/saturate, load, terminal-count pulse; ports clk rst en select load load_val limit sat -> count tc; optional step prescaler under MOD_COUNTER_PRESCALE_EN
module mod_counter #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             select,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic             sat,
    output logic [WIDTH-1:0] count,
    output logic             tc
);
    if (WIDTH < 2 || WIDTH > 32 || PRESCALE < 1 || PRESCALE > 256) begin : g_bad_params
    end
    logic             step;
    logic             over;
    logic             top;
    logic             bot;
    logic [WIDTH-1:0] nxt;
    logic             nxt_tc;
`ifdef MOD_COUNTER_PRESCALE_EN
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] DIV_LAST = PW'(PRESCALE - 1);
    logic [PW-1:0] div;
    always_ff @(posedge clk)
        div <= (rst || load) ? '0 : !en ? div : (div == DIV_LAST) ? '0 : div + 1'b1;
    assign step = en && !load && (div == DIV_LAST);
`else
    assign step = en && !load;
`endif
    always_comb begin
        over   = count > limit;
        top    = count == limit;
        bot    = count == '0;
        nxt    = over   ? limit :
                 select ? (top ? (sat ? count : '0)    : count + 1'b1) :
                          (bot ? (sat ? count : limit) : count - 1'b1);
        nxt_tc = !over && (select ? top : bot);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            tc    <= 1'b0;
        end else if (load) begin
            count <= (load_val > limit) ? limit : load_val;
            tc    <= 1'b0;
        end else if (step) begin
            count <= nxt;
            tc    <= nxt_tc;
        end else begin
            tc    <= 1'b0;
        end
    end
endmodule
